// File: rtl/ps2_host_tx_if.sv
// Request/status bundle between a command source and the PS/2 host transmitter.
//   tx_data  : byte to send, sampled when the request is accepted
//   tx_valid : send request, accepted on a CLK edge with tx_valid & tx_ready
//   tx_ready : transmitter idle and able to accept a byte
//   busy     : a frame is in flight (used to mute the receive path)
//   tx_done  : one-cycle pulse, frame acknowledged by the device
//   tx_error : one-cycle pulse, frame failed (timeout or no ACK)
// master = command source, slave = transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard over the open-drain
// PS2_CLK/PS2_DAT pair: clock inhibit, request-to-send, data/parity/stop shifted out on
// device-generated falling clock edges, then ACK check. Both pins are only ever driven low or Z.
// Ports:
//   CLK      : system clock
//   reset    : synchronous, active-high
//   PS2_CLK  : PS/2 clock pin, open-drain
//   PS2_DAT  : PS/2 data pin, open-drain
//   bus      : ps2_host_tx_if.slave (tx_data/tx_valid in; tx_ready/busy/tx_done/tx_error out)
// Optional feature: define PS2_TX_RETRY_EN to retry a failed frame up to MAX_RETRY more times
// before reporting tx_error. Without it, every failure reports tx_error at once.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic         CLK,
  input  logic         reset,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DAT,
  ps2_host_tx_if.slave bus
);

  localparam int unsigned InhW = $clog2(INHIBIT_CYCLES);
  localparam int unsigned ToW  = $clog2(TIMEOUT_CYCLES);

  // Counter widths hold at most N-1; the data line drop needs two inhibit cycles.
  if (INHIBIT_CYCLES < 2 || TIMEOUT_CYCLES < 2 || MAX_RETRY > 15) begin : g_bad_params
    $error("ps2_host_tx: INHIBIT_CYCLES/TIMEOUT_CYCLES must be >= 2, MAX_RETRY <= 15");
  end

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StShift,
    StAck,
    StWaitIdle,
    StFail
  } state_e;

  state_e          state_q, state_d;
  logic [9:0]      shift_q, shift_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            clk_low_q, clk_low_d;
  logic            dat_low_q, dat_low_d;
`ifdef PS2_TX_RETRY_EN
  logic [3:0]      retry_q, retry_d;
`endif

  logic [1:0] clk_sync_q, dat_sync_q;
  logic       clk_prev_q;
  logic       clk_s, dat_s, fall, timeout;
  logic       tx_done, tx_error;

  // Open-drain pins: drive low or release, never drive high.
  assign PS2_CLK = clk_low_q ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_low_q ? 1'b0 : 1'bz;

  assign clk_s = clk_sync_q[1];
  assign dat_s = dat_sync_q[1];
  assign fall  = clk_prev_q & ~clk_s;

  // Synchronizers reset to the idle (high) level so reset never creates a false fall.
  always_ff @(posedge CLK) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[0], PS2_CLK};
      dat_sync_q <= {dat_sync_q[0], PS2_DAT};
      clk_prev_q <= clk_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_low_q <= 1'b0;
      dat_low_q <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_low_q <= clk_low_d;
      dat_low_q <= dat_low_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_low_d = clk_low_q;
    dat_low_d = dat_low_q;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    tx_done   = 1'b0;
    tx_error  = 1'b0;
    timeout   = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        if (bus.tx_valid) begin
          // {stop, odd parity, data}; start bit is driven separately during REQ.
          shift_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          clk_low_d = 1'b1;
          state_d   = StInhibit;
`ifdef PS2_TX_RETRY_EN
          retry_d   = '0;
`endif
        end
      end
      StInhibit: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Registered drive: set one cycle early so DAT is low during the last inhibit cycle.
        if (inh_cnt_q >= InhW'(INHIBIT_CYCLES - 2)) dat_low_d = 1'b1;
        if (inh_cnt_q == InhW'(INHIBIT_CYCLES - 1)) begin
          clk_low_d = 1'b0;
          to_cnt_d  = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        to_cnt_d  = to_cnt_q + 1'b1;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (fall) begin
          dat_low_d = ~shift_q[bit_cnt_q];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 4'd9) state_d = StAck;
        end
      end
      StAck: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (fall) state_d = dat_s ? StFail : StWaitIdle;
      end
      StWaitIdle: begin
        to_cnt_d = to_cnt_q + 1'b1;
        if (clk_s && dat_s) begin
          tx_done = 1'b1;
          state_d = StIdle;
        end
      end
      StFail: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        state_d   = StIdle;
`ifdef PS2_TX_RETRY_EN
        if (retry_q < 4'(MAX_RETRY)) begin
          // Lines were released this cycle; re-inhibit from the next edge with the same byte.
          retry_d   = retry_q + 1'b1;
          inh_cnt_d = '0;
          to_cnt_d  = '0;
          bit_cnt_d = '0;
          clk_low_d = 1'b1;
          state_d   = StInhibit;
        end else begin
          tx_error = 1'b1;
        end
`else
        tx_error = 1'b1;
`endif
      end
      default: begin
        clk_low_d = 1'b0;
        dat_low_d = 1'b0;
        state_d   = StIdle;
      end
    endcase

    // Timeout overrides anything the state decided this cycle, including a fall or a done.
    if ((state_q == StReq || state_q == StShift || state_q == StAck || state_q == StWaitIdle) &&
        to_cnt_q == ToW'(TIMEOUT_CYCLES - 1)) begin
      timeout   = 1'b1;
      tx_done   = 1'b0;
      clk_low_d = 1'b0;
      dat_low_d = 1'b0;
      state_d   = StFail;
    end
  end

  assign bus.tx_ready = (state_q == StIdle);
  assign bus.busy     = (state_q != StIdle);
  assign bus.tx_done  = tx_done;
  assign bus.tx_error = tx_error;

endmodule
